// File: rtl/uart_rx_word.sv
// UART 8N1 receiver that packs byte pairs into 16-bit words behind a valid/ready handshake.
// Define UART_RX_PARITY_EN for 8E1 framing (even parity bit checked before the stop bit).
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 87,
    parameter bit HI_FIRST     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        rx,
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             half_q, half_d;
    logic [15:0]      word_q, word_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    logic        byte_done;
    logic        xfer;
    logic        stop_ok;
    logic [15:0] new_word;

    assign new_word = HI_FIRST ? {hold_q, shift_q} : {shift_q, hold_q};

`ifdef UART_RX_PARITY_EN
    assign stop_ok = rx_s_q & ~par_err_q;
`else
    assign stop_ok = rx_s_q;
`endif

    always_comb begin
        state_d     = state_q;
        rx_meta_d   = rx_meta_q;
        rx_s_d      = rx_s_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        half_d      = half_q;
        word_d      = word_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        byte_done   = 1'b0;
        xfer        = 1'b0;

        if (ce) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
            rx_meta_d   = rx;
            rx_s_d      = rx_meta_q;
            cnt_d       = cnt_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s_q) state_d = S_START;
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            bit_d   = 3'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d     = '0;
                        par_err_d = rx_s_q ^ (^shift_q);
                        state_d   = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d = '0;
                        if (stop_ok) begin
                            byte_done = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            // a bad byte also breaks any pairing in progress
                            frame_err_d = 1'b1;
                            half_d      = 1'b0;
                            state_d     = rx_s_q ? S_IDLE : S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    cnt_d = '0;
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            xfer = valid_q & word_ready;
            if (xfer) valid_d = 1'b0;

            if (byte_done) begin
                if (!half_q) begin
                    hold_d = shift_q;
                    half_d = 1'b1;
                end else begin
                    half_d = 1'b0;
                    // the held word wins; a completed word with nowhere to go is dropped
                    if (!valid_q || xfer) begin
                        word_d  = new_word;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            half_q      <= 1'b0;
            word_q      <= 16'h0000;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            half_q      <= half_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE) | half_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word: two instances (HI_FIRST=1 and 0) fed the same serial stream.
module tb_uart_rx_word;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst_n, ce, rx, word_ready;
    logic [15:0] wo [2];
    logic        wv [2];
    logic        fe [2];
    logic        ov [2];
    logic        bz [2];

    always #5 clk = ~clk;

    uart_rx_word #(.CLKS_PER_BIT(CPB), .HI_FIRST(1'b1)) u_hi (
        .clk(clk), .rst_n(rst_n), .ce(ce), .rx(rx), .word_out(wo[0]), .word_valid(wv[0]),
        .word_ready(word_ready), .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0]));
    uart_rx_word #(.CLKS_PER_BIT(CPB), .HI_FIRST(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .ce(ce), .rx(rx), .word_out(wo[1]), .word_valid(wv[1]),
        .word_ready(word_ready), .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1]));

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] exp_q [2][$];
    int          exp_fe = 0, exp_ov = 0;
    bit          mdl_half = 0, mdl_full = 0;
    logic [7:0]  mdl_hold = 8'h00;

    // monitor-side observations
    int          fe_cnt [2] = '{0, 0};
    int          ov_cnt [2] = '{0, 0};
    bit          pv [2] = '{0, 0};
    bit          pxf [2] = '{0, 0};
    logic [15:0] pw [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [15:0] e;
            bit xf;
            if (!rst_n) begin
                pv[k]  = 0;
                pxf[k] = 0;
            end else begin
                if (pv[k] && !pxf[k]) begin
                    total++;
                    if (!wv[k] || wo[k] != pw[k]) begin
                        bad++;
                        $display("FAIL hold[%0d]: valid=%0b word=%h, required valid=1 word=%h", k, wv[k], wo[k], pw[k]);
                    end
                end
                if (fe[k]) fe_cnt[k]++;
                if (ov[k]) ov_cnt[k]++;
                xf = wv[k] && word_ready && ce;
                if (xf) begin
                    total++;
                    if (exp_q[k].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_word[%0d]: got %h with nothing expected", k, wo[k]);
                    end else begin
                        e = exp_q[k].pop_front();
                        if (wo[k] != e) begin
                            bad++;
                            $display("FAIL word[%0d]: got %h, required %h", k, wo[k], e);
                        end
                    end
                end
                pv[k]  = wv[k];
                pw[k]  = wo[k];
                pxf[k] = xf;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic checkpoint(input string name);
        for (int k = 0; k < 2; k++) begin
            chk({name, "_frame_err_count"}, fe_cnt[k], exp_fe);
            chk({name, "_overrun_count"}, ov_cnt[k], exp_ov);
            chk({name, "_busy"}, int'(bz[k]), int'(mdl_half));
            chk({name, "_pending_words"}, exp_q[k].size(), int'(mdl_full));
        end
    endtask

    task automatic set_ready(input bit b);
        word_ready = b;
        if (b) mdl_full = 0;
        tick(2);
    endtask

    // model update happens before the stop bit is driven so expectations lead the DUT
    task automatic send_byte(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        bit good;
`ifdef UART_RX_PARITY_EN
        good = stop_ok && par_ok;
`else
        good = stop_ok;
`endif
        if (good) begin
            if (!mdl_half) begin
                mdl_hold = d;
                mdl_half = 1;
            end else begin
                mdl_half = 0;
                if (mdl_full) begin
                    exp_ov++;
                end else begin
                    exp_q[0].push_back({mdl_hold, d});
                    exp_q[1].push_back({d, mdl_hold});
                    mdl_full = !word_ready;
                end
            end
        end else begin
            exp_fe++;
            mdl_half = 0;
        end
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ !par_ok;
        tick(CPB);
`endif
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; rx = 1'b1; word_ready = 1'b1;
        tick(3);
        for (int k = 0; k < 2; k++) begin
            chk("reset_word_out", int'(wo[k]), 0);
            chk("reset_word_valid", int'(wv[k]), 0);
            chk("reset_busy", int'(bz[k]), 0);
            chk("reset_pulses", int'(fe[k]) + int'(ov[k]), 0);
        end
        rst_n = 1'b1;
        tick(4);

        set_ready(1);
        send_byte(8'hA5, 1, 1);
        chk("half_busy", int'(bz[0]), 1);
        send_byte(8'h3C, 1, 1);
        checkpoint("basic");

        set_ready(0);
        send_byte(8'h12, 1, 1);
        send_byte(8'h34, 1, 1);
        checkpoint("held");
        send_byte(8'h56, 1, 1);
        send_byte(8'h78, 1, 1);
        checkpoint("overrun");
        set_ready(1);
        tick(3);
        checkpoint("drain");

        // ce low must block the handshake even with ready high
        set_ready(0);
        send_byte(8'h9A, 1, 1);
        send_byte(8'hBC, 1, 1);
        ce = 1'b0;
        word_ready = 1'b1;
        tick(6);
        checkpoint("ce_hold");
        ce = 1'b1;
        mdl_full = 0;
        tick(3);
        checkpoint("ce_release");

        send_byte(8'h11, 1, 1);
        send_byte(8'h22, 0, 1);
        checkpoint("bad_stop");
        send_byte(8'h33, 1, 1);
        send_byte(8'h44, 1, 1);
        checkpoint("after_bad_stop");

        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(3 * CPB);
        checkpoint("glitch");

        send_byte(8'h11, 1, 1);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            tick(CPB);
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midframe_reset_outputs",
                int'(wo[k]) + int'(wv[k]) + int'(fe[k]) + int'(ov[k]) + int'(bz[k]), 0);
        end
        mdl_half = 0;
        mdl_full = 0;
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2 * CPB);
        send_byte(8'hBE, 1, 1);
        send_byte(8'hEF, 1, 1);
        checkpoint("after_reset");

`ifdef UART_RX_PARITY_EN
        send_byte(8'h03, 1, 0);
        checkpoint("parity_bad");
        send_byte(8'h03, 1, 1);
        send_byte(8'h07, 1, 1);
        checkpoint("parity_good");
`endif

        for (int r = 0; r < 40; r++) begin
            set_ready(1'($urandom_range(0, 1)));
            for (int b = 0; b < int'($urandom_range(2, 4)); b++) begin
                send_byte(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
            end
            checkpoint("random");
        end

        set_ready(1);
        tick(4);
        checkpoint("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
